jpeg_bit_packer: RTL
====================

# jpeg_bit_packer

Serialises the variable-length Huffman codes produced by the JPEG encoder pipeline into a byte-aligned entropy-coded stream. It sits directly downstream of the encoder's code/length outputs and is the receiving end of that interface. It accepts one (code, length) pair per cycle under valid/ready flow control and emits bytes MSB-first. It performs JPEG 0xFF byte stuffing and, on flush, pads the final partial byte with 1s.

## Interface
Parameters:
- ACC_W, 32: bit accumulator width; must be ≥ 24.
- MAX_LEN, 16: maximum code length accepted.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- code_valid  in  1  a code is presented on code_data/code_len.
- code_ready  out  1  the packer can accept a code this cycle.
- code_data  in  16  code bits, right-justified; bits at or above code_len are ignored (masked).
- code_len  in  5  number of valid bits, 0..16. 0 is a legal no-op. Values 17..31 saturate to 16.
- flush  in  1  single-cycle request to pad and drain all buffered bits.
- byte_valid  out  1  byte_data holds an output byte.
- byte_data  out  8  output byte.
- byte_ready  in  1  downstream accepts the byte.
- flush_done  out  1  one-cycle pulse after the last flushed byte is accepted.

## Operation
- **Accumulator and fill level.** acc holds the queued bits MSB-aligned at bit ACC_W-1. bit_cnt (0..ACC_W) is the number of valid bits.
- **Accepting a code.** A code is accepted when code_valid and code_ready are both high. Its masked bits are appended immediately below the existing bit_cnt bits.
- **code_ready.** code_ready = (state == RUN) && (bit_cnt ≤ ACC_W-MAX_LEN). It is combinational from registers only.
- **Output register.** byte_data/byte_valid form a one-entry output register. It loads when (!byte_valid || byte_ready). byte_data stays stable while byte_valid && !byte_ready.
- **Drain.** In RUN, when bit_cnt ≥ 8 and the output register is free, the top 8 bits of acc load into it. acc then shifts left by 8 and bit_cnt decreases by 8.
- **Simultaneous accept and drain.** Both may occur in the same cycle. bit_cnt_next = bit_cnt + len − (drain ? 8 : 0).
- **State machine** (states RUN, STUFF, PAD, FLUSH, DONE):
  - RUN → STUFF when a byte 0xFF is loaded into the output register (macro enabled only).
  - STUFF: the next free output slot loads 0x00, then the FSM returns to the pending state, RUN or FLUSH. No drain occurs while in STUFF.
  - RUN → PAD when flush is sampled high. A flush arriving on a code-accept cycle includes that code.
  - PAD: if bit_cnt mod 8 ≠ 0, append 1-bits up to the next byte boundary. One cycle, then → FLUSH.
  - FLUSH: drain as in RUN, stuffing still applies. When bit_cnt == 0 and the last byte has been accepted (byte_valid low or byte_ready high) → DONE.
  - DONE: flush_done = 1 for one cycle → RUN.
- **flush outside RUN** is ignored.
- **Reset.** Reset, including mid-stream, clears acc, bit_cnt and the output register. state = RUN.
- **Reset values:** byte_valid 0, byte_data 0x00, flush_done 0. code_ready becomes 1 after the first clock edge following reset release.

## Timing
- A code accepted at edge N can produce byte_valid at edge N+1 at the earliest.
- Throughput:
  - Up to one byte per cycle on output.
  - Input is sustained at 1 code/cycle while average code length is ≤ 8 bits.
  - Longer codes are backpressured via code_ready.
- Stuffing costs one output cycle per 0xFF.
- Flush latency with byte_ready held high is 1 (PAD) + ceil(bits/8) + stuffed bytes + 1 (DONE) cycles.
- No combinational path from byte_ready to code_ready.

## Configuration
- JPEG_BYTE_STUFF_EN defined: every emitted 0xFF is followed by 0x00 via the STUFF state.
- JPEG_BYTE_STUFF_EN undefined: STUFF is unreachable and may be omitted, and 0xFF is emitted unmodified. This mode is used for raw bit-order checking against the encoder model.

## Structure
- Shared package `jpeg_pkg`:
  - State encoding localparams.
  - Stuff byte constant 0x00 and marker constant 0xFF.
  - MAX_LEN and the default ACC_W.
- One natural sub-module: `jpeg_bit_mask_align`. It is combinational; it masks code_data to code_len and left-aligns it at offset bit_cnt within ACC_W.

## Test plan
- Codes 3'b101 then 5'b11111, byte_ready=1 → one byte 0xBF; bit_cnt returns to 0.
- Code 8'hFF, len 8, macro defined → bytes 0xFF, 0x00 on consecutive cycles. Macro undefined → single 0xFF.
- Code 1'b0, len 1, then flush → byte 0x7F, then flush_done pulses exactly once, one cycle after acceptance.
- Codes 16'h1234, 16'hABCD back-to-back with byte_ready=1 → 0x12, 0x34, 0xAB, 0xCD in order. code_ready deasserts while bit_cnt > 16.
- byte_ready held low 5 cycles with a byte pending → byte_data stable, no bytes lost or duplicated. code_ready falls once bit_cnt > 16.
- reset_n pulsed low mid-stream with 13 bits buffered → byte_valid 0 immediately. After release, the next code 8'h5A yields only 0x5A.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared constants and state encoding for the JPEG entropy-stream bit packer.
package jpeg_pkg;

    localparam int JPEG_ACC_W   = 32;
    localparam int JPEG_MAX_LEN = 16;

    localparam logic [7:0] JPEG_MARKER_BYTE = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_BYTE  = 8'h00;

    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_STUFF = 3'd1;
    localparam logic [2:0] ST_PAD   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        RUN   = ST_RUN,
        STUFF = ST_STUFF,
        PAD   = ST_PAD,
        FLUSH = ST_FLUSH,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/jpeg_bit_packer_if.sv
// Code-in / byte-out bundle between the Huffman encoder, the bit packer and the stream sink.
interface jpeg_bit_packer_if;
    import jpeg_pkg::*;

    // Both channels use valid/ready: a transfer happens on a rising clock edge where
    // valid and ready are both high; the sender holds its payload stable while valid
    // is high and ready is low, and ready never depends combinationally on valid.
    logic                    code_valid;
    logic                    code_ready;
    logic [JPEG_MAX_LEN-1:0] code_data;
    logic [4:0]              code_len;
    logic                    flush;
    logic                    byte_valid;
    logic [7:0]              byte_data;
    logic                    byte_ready;
    logic                    flush_done;

    modport master (
        output code_valid, code_data, code_len, flush, byte_ready,
        input  code_ready, byte_valid, byte_data, flush_done
    );

    modport slave (
        input  code_valid, code_data, code_len, flush, byte_ready,
        output code_ready, byte_valid, byte_data, flush_done
    );

endinterface

// File: rtl/jpeg_bit_mask_align.sv
// Masks a right-justified code to its (saturated) length and places it just below
// the bit_cnt bits already queued in an MSB-aligned accumulator.
module jpeg_bit_mask_align
    import jpeg_pkg::*;
#(
    parameter int ACC_W   = JPEG_ACC_W,
    parameter int MAX_LEN = JPEG_MAX_LEN,
    parameter int CNT_W   = $clog2(JPEG_ACC_W + 1)
) (
    input  logic [JPEG_MAX_LEN-1:0] code_data,
    input  logic [4:0]              code_len,
    input  logic [CNT_W-1:0]        bit_cnt,
    output logic [4:0]              len_sat,
    output logic [ACC_W-1:0]        aligned
);

    logic [JPEG_MAX_LEN:0]   mask;
    logic [JPEG_MAX_LEN-1:0] masked;
    logic [ACC_W-1:0]        ext;
    logic [CNT_W-1:0]        lsh;

    always_comb begin
        len_sat = (code_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : code_len;
        mask    = ({{JPEG_MAX_LEN{1'b0}}, 1'b1} << len_sat) - {{JPEG_MAX_LEN{1'b0}}, 1'b1};
        masked  = code_data & mask[JPEG_MAX_LEN-1:0];
        ext     = {{(ACC_W-JPEG_MAX_LEN){1'b0}}, masked};
        // Push the code to the top first, then down past the queued bits; both shifts
        // are non-negative, so no signed offset arithmetic is needed.
        lsh     = CNT_W'(ACC_W) - CNT_W'(len_sat);
        aligned = (ext << lsh) >> bit_cnt;
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs variable-length Huffman codes into an MSB-first byte stream with pad-on-flush.
// Define JPEG_BYTE_STUFF_EN to insert 0x00 after every emitted 0xFF.
module jpeg_bit_packer
    import jpeg_pkg::*;
#(
    parameter int ACC_W   = JPEG_ACC_W,
    parameter int MAX_LEN = JPEG_MAX_LEN
) (
    input  logic                clock,
    input  logic                reset_n,
    jpeg_bit_packer_if.slave    bus,
    output state_t              state_dbg
);

    localparam int               CNT_W      = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] READY_MAX  = CNT_W'(ACC_W - MAX_LEN);
    localparam logic [CNT_W-1:0] BYTE_BITS  = CNT_W'(8);
    localparam logic [CNT_W-1:0] ROUND_ADD  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ROUND_MASK = ~CNT_W'(7);
`ifdef JPEG_BYTE_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    state_t           state, ret_state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] bit_cnt;
    logic             byte_valid_q, flush_done_q, started;
    logic [7:0]       byte_data_q;

    logic [4:0]       len_sat;
    logic [ACC_W-1:0] aligned, acc_app, acc_next, pad_mask;
    logic [CNT_W-1:0] cnt_app, cnt_next, cnt_round;
    logic             code_ready_int, accept, out_free, can_drain, need_stuff;
    logic [7:0]       top_byte;

    jpeg_bit_mask_align #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_align (
        .code_data (bus.code_data),
        .code_len  (bus.code_len),
        .bit_cnt   (bit_cnt),
        .len_sat   (len_sat),
        .aligned   (aligned)
    );

    always_comb begin
        code_ready_int = started && (state == RUN) && (bit_cnt <= READY_MAX);
        accept         = bus.code_valid && code_ready_int;
        out_free       = !byte_valid_q || bus.byte_ready;
        can_drain      = ((state == RUN) || (state == FLUSH)) && (bit_cnt >= BYTE_BITS) && out_free;
        top_byte       = acc[ACC_W-1 -: 8];
        need_stuff     = STUFF_EN && can_drain && (top_byte == JPEG_MARKER_BYTE);
        // Appended bits sit below bit_cnt, so the drained top byte is never affected.
        acc_app        = accept ? (acc | aligned) : acc;
        cnt_app        = accept ? (bit_cnt + CNT_W'(len_sat)) : bit_cnt;
        acc_next       = can_drain ? (acc_app << 8) : acc_app;
        cnt_next       = can_drain ? (cnt_app - BYTE_BITS) : cnt_app;
        cnt_round      = (bit_cnt + ROUND_ADD) & ROUND_MASK;
        pad_mask       = ({ACC_W{1'b1}} >> bit_cnt) & ~({ACC_W{1'b1}} >> cnt_round);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            ret_state    <= RUN;
            acc          <= '0;
            bit_cnt      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            flush_done_q <= 1'b0;
            started      <= 1'b0;
        end else begin
            started      <= 1'b1;
            flush_done_q <= 1'b0;
            if (byte_valid_q && bus.byte_ready)
                byte_valid_q <= 1'b0;
            case (state)
                RUN: begin
                    acc     <= acc_next;
                    bit_cnt <= cnt_next;
                    if (can_drain) begin
                        byte_data_q  <= top_byte;
                        byte_valid_q <= 1'b1;
                    end
                    if (need_stuff) begin
                        state     <= STUFF;
                        ret_state <= bus.flush ? PAD : RUN;
                    end else if (bus.flush) begin
                        state <= PAD;
                    end
                end
                STUFF: begin
                    if (out_free) begin
                        byte_data_q  <= JPEG_STUFF_BYTE;
                        byte_valid_q <= 1'b1;
                        state        <= ret_state;
                    end
                end
                PAD: begin
                    acc     <= acc | pad_mask;
                    bit_cnt <= cnt_round;
                    state   <= FLUSH;
                end
                FLUSH: begin
                    acc     <= acc_next;
                    bit_cnt <= cnt_next;
                    if (can_drain) begin
                        byte_data_q  <= top_byte;
                        byte_valid_q <= 1'b1;
                    end
                    if (need_stuff) begin
                        state     <= STUFF;
                        ret_state <= FLUSH;
                    end else if ((bit_cnt == '0) && out_free) begin
                        state        <= DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.code_ready = code_ready_int;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.flush_done = flush_done_q;
    assign state_dbg      = state;

endmodule
